// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus-source arbiter feeding the 32-to-5 bus-select encoder.
// No logic; latency and backpressure are set by the arbiter that imports this package.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam int SRC_IDX_W = 5;
  localparam int GRANT_W   = 32;
  localparam logic [SRC_IDX_W-1:0] NO_SRC_CODE = 5'd31;

  localparam int R0     = 0;
  localparam int R1     = 1;
  localparam int R2     = 2;
  localparam int R3     = 3;
  localparam int R4     = 4;
  localparam int R5     = 5;
  localparam int R6     = 6;
  localparam int R7     = 7;
  localparam int R8     = 8;
  localparam int R9     = 9;
  localparam int R10    = 10;
  localparam int R11    = 11;
  localparam int R12    = 12;
  localparam int R13    = 13;
  localparam int R14    = 14;
  localparam int R15    = 15;
  localparam int HI     = 16;
  localparam int LO     = 17;
  localparam int ZHI    = 18;
  localparam int ZLO    = 19;
  localparam int PC     = 20;
  localparam int MDR    = 21;
  localparam int INPORT = 22;
  localparam int C      = 23;

  // Same mapping the downstream encoder applies: an empty vector maps to NO_SRC_CODE.
  function automatic logic [SRC_IDX_W-1:0] onehot_idx(input logic [GRANT_W-1:0] v);
    onehot_idx = NO_SRC_CODE;
    for (int i = 0; i < GRANT_W; i++) begin
      if (v[i]) onehot_idx = SRC_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/bus_source_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker, first set req bit at or after ptr, wrapping.
// Zero latency; no backpressure, pick_vld is low when nothing is requesting.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NUM_SRC = 24
) (
  input  logic [NUM_SRC-1:0]   req,
  input  logic [SRC_IDX_W-1:0] ptr,
  output logic [NUM_SRC-1:0]   pick,
  output logic                 pick_vld
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  always_comb begin : scan
    int              idx;
    logic [IW-1:0]   idx_w;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    idx_w    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      idx_w = IW'(idx);
      if (!pick_vld && req[idx_w]) begin
        pick[idx_w] = 1'b1;
        pick_vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin one-hot bus grant with a dead cycle between owners; optional hold limit under ARB_TIMEOUT_EN.
// Latency: req to grant 1 cycle when idle; other sources wait while a grant is held (no backpressure path).
module bus_source_arbiter #(
  parameter int NUM_SRC     = 24,
  parameter int GRANT_W     = bus_arb_pkg::GRANT_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [NUM_SRC-1:0] req,
  input  logic               xfer_done,
  output logic [GRANT_W-1:0] grant,
  output logic               busy,
  output logic               multi_req,
  output logic               timeout
);

  import bus_arb_pkg::*;

  if (NUM_SRC < 2 || NUM_SRC > C + 1) begin : g_bad_num_src
    $error("bus_source_arbiter: NUM_SRC out of range 2-24");
  end
  if (GRANT_W != bus_arb_pkg::GRANT_W) begin : g_bad_grant_w
    $error("bus_source_arbiter: GRANT_W must match encoder width");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 256) begin : g_bad_timeout
    $error("bus_source_arbiter: TIMEOUT_CYC out of range 2-256");
  end

  arb_state_e                 state_q, state_d;
  logic [SRC_IDX_W-1:0]       ptr_q, ptr_d;
  logic [NUM_SRC-1:0]         grant_q, grant_d;
  logic                       multi_req_q, multi_req_d;

  logic [NUM_SRC-1:0]         pick;
  logic                       pick_vld;
  logic [bus_arb_pkg::GRANT_W-1:0] pick_w;
  logic [SRC_IDX_W-1:0]       pick_idx;
  logic                       owner_drop;

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_pick (
    .req      (req),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_vld (pick_vld)
  );

  always_comb begin
    pick_w              = '0;
    pick_w[NUM_SRC-1:0] = pick;
    pick_idx            = onehot_idx(pick_w);
  end

  // The owner releases when its own request falls or the transfer completes; both at once is one release.
  assign owner_drop = ~(|(req & grant_q)) | xfer_done;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT_CYC - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    multi_req_d = ($countones(req) >= 2);
`ifdef ARB_TIMEOUT_EN
    hold_d      = hold_q;
    timeout_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE, RELEASE: begin
        if (pick_vld) begin
          state_d = GRANT;
          grant_d = pick;
          ptr_d   = (pick_idx == SRC_IDX_W'(NUM_SRC - 1)) ? '0 : pick_idx + SRC_IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      GRANT: begin
        if (owner_drop) begin
          state_d = RELEASE;
          grant_d = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          state_d   = RELEASE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      multi_req_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      multi_req_q <= multi_req_d;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= hold_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  always_comb begin
    grant              = '0;
    grant[NUM_SRC-1:0] = grant_q;
  end

  assign busy      = (state_q == GRANT);
  assign multi_req = multi_req_q;

`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed bench for bus_source_arbiter: reset, single grant, round-robin wrap, combined release, mid-grant reset, hold limit.
module tb_bus_source_arbiter;

  logic        clock;
  logic        clear;
  logic [23:0] req;
  logic        xfer_done;
  logic [31:0] grant;
  logic        busy;
  logic        multi_req;
  logic        timeout;

  int n_checks = 0;
  int n_err    = 0;

  bus_source_arbiter #(
    .NUM_SRC     (24),
    .GRANT_W     (32),
    .TIMEOUT_CYC (4)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .req       (req),
    .xfer_done (xfer_done),
    .grant     (grant),
    .busy      (busy),
    .multi_req (multi_req),
    .timeout   (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] enc(input logic [31:0] v);
    logic [4:0] r;
    r = 5'd31;
    for (int i = 0; i < 32; i++) if (v[i]) r = 5'(i);
    return r;
  endfunction

  initial begin
    logic stuck_ok;
    logic to_seen;

    clear     = 1'b1;
    req       = 24'hFFFFFF;
    xfer_done = 1'b0;
    tick();
    tick();
    chk("rst_grant", grant, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_multi", {31'b0, multi_req}, 32'h0);
    chk("rst_timeout", {31'b0, timeout}, 32'h0);

    clear = 1'b0;
    req   = 24'h0;
    tick();
    chk("idle_grant", grant, 32'h0);
    chk("idle_enc", {27'b0, enc(grant)}, 32'd31);

    // single request
    req = 24'h000010;
    tick();
    chk("single_grant", grant, 32'h00000010);
    chk("single_busy", {31'b0, busy}, 32'h1);
    chk("single_multi", {31'b0, multi_req}, 32'h0);
    tick();
    chk("single_hold", grant, 32'h00000010);
    req = 24'h0;
    tick();
    chk("single_dead", grant, 32'h0);
    chk("single_dead_busy", {31'b0, busy}, 32'h0);
    tick();
    chk("single_idle", grant, 32'h0);

    // round robin with wrap, starting from ptr=0
    clear = 1'b1;
    tick();
    clear = 1'b0;
    req   = 24'h800001;
    tick();
    chk("rr_g0", grant, 32'h00000001);
    chk("rr_multi0", {31'b0, multi_req}, 32'h1);
    xfer_done = 1'b1;
    tick();
    chk("rr_dead0", grant, 32'h0);
    xfer_done = 1'b0;
    tick();
    chk("rr_g23", grant, 32'h00800000);
    chk("rr_multi1", {31'b0, multi_req}, 32'h1);
    xfer_done = 1'b1;
    tick();
    chk("rr_dead1", grant, 32'h0);
    xfer_done = 1'b0;
    tick();
    chk("rr_wrap_g0", grant, 32'h00000001);
    chk("rr_multi2", {31'b0, multi_req}, 32'h1);
    req = 24'h0;
    tick();
    chk("rr_end_dead", grant, 32'h0);
    chk("rr_multi_clr", {31'b0, multi_req}, 32'h0);

    // simultaneous req drop and xfer_done, other requester ignored while held
    req = 24'h000020;
    tick();
    chk("sim_g5", grant, 32'h00000020);
    req = 24'h0000A0;
    tick();
    chk("sim_ignore7", grant, 32'h00000020);
    chk("sim_multi", {31'b0, multi_req}, 32'h1);
    req       = 24'h000080;
    xfer_done = 1'b1;
    tick();
    chk("sim_dead", grant, 32'h0);
    xfer_done = 1'b0;
    tick();
    chk("sim_g7", grant, 32'h00000080);
    chk("sim_busy", {31'b0, busy}, 32'h1);

    // reset while PC holds the bus
    req = 24'h0;
    tick();
    req = 24'h100000;
    tick();
    chk("mid_g20", grant, 32'h00100000);
    clear = 1'b1;
    req   = 24'h100001;
    tick();
    chk("mid_rst_grant", grant, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_multi", {31'b0, multi_req}, 32'h0);
    clear = 1'b0;
    tick();
    chk("mid_g0", grant, 32'h00000001);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    tick();
    chk("mid_next_g20", grant, 32'h00100000);

    // hold limit
    clear = 1'b1;
    req   = 24'h0;
    tick();
    clear = 1'b0;
    req   = 24'h000008;
    tick();
    chk("to_g3", grant, 32'h00000008);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("to_hold", grant, 32'h00000008);
      chk("to_no_pulse", {31'b0, timeout}, 32'h0);
    end
    tick();
    chk("to_release", grant, 32'h0);
    chk("to_pulse", {31'b0, timeout}, 32'h1);
    tick();
    chk("to_pulse_end", {31'b0, timeout}, 32'h0);
    chk("to_regrant", grant, 32'h00000008);
`else
    stuck_ok = 1'b1;
    to_seen  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (grant !== 32'h00000008) stuck_ok = 1'b0;
      if (timeout !== 1'b0) to_seen = 1'b1;
    end
    chk("nto_held", {31'b0, stuck_ok}, 32'h1);
    chk("nto_timeout", {31'b0, to_seen}, 32'h0);
    chk("nto_busy", {31'b0, busy}, 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
